seg7_capture_decoder: RTL

- Receive-side counterpart of the nibble-to-7-segment encoder.
- Samples seven externally driven segment lines (PMOD inputs, asynchronous, active-low by default), synchronises and glitch-filters them, then decodes the stable pattern back to a hex nibble.
- Flags blank and illegal patterns and counts decode errors.
- Used to loop back and verify the display path on a second board, or from PMOD into the same board.

---
 rtl/seg7_capture_decoder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/seg7_capture_decoder.sv
// seg7_capture_decoder: samples asynchronous 7-segment pins, debounces them
// and decodes the accepted glyph back to a hex nibble with error counting.
module seg7_capture_decoder #(
    parameter int STABLE_CYCLES = 250000,
    parameter bit INVERT        = 1'b1
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [6:0] i_Segments,
    output logic [3:0] o_Nibble,
    output logic       o_Valid,
    output logic       o_Blank,
    output logic       o_Update,
    output logic [7:0] o_Error_Count
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [6:0] POL = {7{INVERT}};
    localparam logic [6:0] PIN_BLANK = POL;

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [6:0]    sync1_q;
    logic [6:0]    sync2_q;
    logic [6:0]    cand_q;
    logic [6:0]    accepted_q;
    logic [CW-1:0] count_q;

    logic [6:0] seg_s;
    logic       match;
    logic       accept;
    logic       is_legal;
    logic       is_blank;
    logic [3:0] glyph_val;

    // Glyph table in logical polarity; bit 4 flags a legal glyph.
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        r = 5'h00;
        case (p)
            7'h3F: r = {1'b1, 4'h0};
            7'h06: r = {1'b1, 4'h1};
            7'h5B: r = {1'b1, 4'h2};
            7'h4F: r = {1'b1, 4'h3};
            7'h66: r = {1'b1, 4'h4};
            7'h6D: r = {1'b1, 4'h5};
            7'h7D: r = {1'b1, 4'h6};
            7'h07: r = {1'b1, 4'h7};
            7'h7F: r = {1'b1, 4'h8};
            7'h6F: r = {1'b1, 4'h9};
            7'h77: r = {1'b1, 4'hA};
            7'h7C: r = {1'b1, 4'hB};
            7'h39: r = {1'b1, 4'hC};
            7'h5E: r = {1'b1, 4'hD};
            7'h79: r = {1'b1, 4'hE};
            7'h71: r = {1'b1, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // Two-flop synchroniser; reset parks the pins at the blank level.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync1_q <= PIN_BLANK;
            sync2_q <= PIN_BLANK;
        end else begin
            sync1_q <= i_Segments;
            sync2_q <= sync1_q;
        end
    end

    // Polarity correction, stability match and acceptance decision.
    always_comb begin
        seg_s = sync2_q ^ POL;
        match = (seg_s == cand_q);
        accept = match && (count_q == CNT_MAX) &&
                 ((state_q == UNLOCKED) || (cand_q != accepted_q));
        {is_legal, glyph_val} = decode(cand_q);
        is_blank = (cand_q == 7'h00);
    end

    // Stability filter: any change reloads the candidate and restarts count.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            cand_q  <= 7'h00;
            count_q <= CNT_ZERO;
        end else if (!match) begin
            cand_q  <= seg_s;
            count_q <= CNT_ZERO;
        end else if (count_q != CNT_MAX) begin
            count_q <= count_q + CNT_ONE;
        end
    end

    // Lock state register.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next lock state: the first acceptance locks and it stays locked.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            UNLOCKED: if (accept) state_d = LOCKED;
            LOCKED:   state_d = LOCKED;
            default:  state_d = UNLOCKED;
        endcase
    end

    // Remember the last accepted pattern to suppress re-pulsing.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            accepted_q <= 7'h00;
        end else if (accept) begin
            accepted_q <= cand_q;
        end
    end

    // Registered outputs refreshed once per accepted pattern.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Nibble      <= 4'h0;
            o_Valid       <= 1'b0;
            o_Blank       <= 1'b0;
            o_Update      <= 1'b0;
            o_Error_Count <= 8'h00;
        end else begin
            o_Update <= accept;
            if (accept) begin
                unique case (1'b1)
                    is_legal: begin
                        o_Nibble <= glyph_val;
                        o_Valid  <= 1'b1;
                        o_Blank  <= 1'b0;
                    end
                    is_blank: begin
                        o_Valid <= 1'b0;
                        o_Blank <= 1'b1;
                    end
                    default: begin
                        o_Valid <= 1'b0;
                        o_Blank <= 1'b0;
                        if (o_Error_Count != 8'hFF) begin
                            o_Error_Count <= o_Error_Count + 8'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
